// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive controller and the future transmitter.
// Provides the one-hot receiver state encoding, the parity mode constants and
// the width/midpoint helpers used to size the oversample and bit counters.
package uart_pkg;

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        START    = 6'b000010,
        DATA     = 6'b000100,
        PARITY   = 6'b001000,
        STOP     = 6'b010000,
        BRK_WAIT = 6'b100000
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Number of bits needed to hold values 0..value-1 (ceil(log2(value))).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w    = 0;
        int unsigned span = 1;
        while (span < value) begin
            span = span << 1;
            w    = w + 1;
        end
        return w;
    endfunction

    // Oversample index at the centre of a bit.
    function automatic int unsigned mid_point(input int unsigned oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversample counter and 3-sample majority voter for the UART receiver.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   baud_tick    - one-cycle oversample strobe; the counter only moves on ticks
//   rxd          - synchronised serial input
//   restart      - hold the counter at 0 (receiver idle / waiting)
//   cnt          - oversample position within the current bit
//   vote         - majority of samples at MID-1, MID and MID+1 (valid with vote_strobe)
//   vote_strobe  - tick on which the vote is resolved (cnt = MID+1)
//   bit_end      - tick on which cnt wraps (cnt = OVERSAMPLE-1)
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter  int unsigned OVERSAMPLE = 16,
    localparam int unsigned CW         = clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          baud_tick,
    input  logic          rxd,
    input  logic          restart,
    output logic [CW-1:0] cnt,
    output logic          vote,
    output logic          vote_strobe,
    output logic          bit_end
);

    localparam int unsigned   MID      = mid_point(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);

    logic s0;
    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            s0  <= 1'b0;
            s1  <= 1'b0;
        end else if (baud_tick) begin
            if (restart) begin
                cnt <= '0;
            end else begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (cnt == CNT_S0) s0 <= rxd;
                if (cnt == CNT_S1) s1 <= rxd;
            end
        end
    end

    // Third sample is taken live on the vote tick.
    assign vote        = (s0 & s1) | (s0 & rxd) | (s1 & rxd);
    assign vote_strobe = baud_tick && !restart && (cnt == CNT_VOTE);
    assign bit_end     = baud_tick && !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Parametrised UART receive controller.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (aborts any frame)
//   baud_tick    - oversample strobe from the baud-rate generator
//   rxd          - synchronised serial input
//   rx_rd        - host read; clears data_avail and overrun_err
//   rx_data      - last completed frame
//   rx_valid     - one-cycle pulse per completed frame (errored frames included)
//   data_avail   - unread frame held in rx_data
//   parity_err   - parity error for the frame in rx_data
//   frame_err    - a stop bit was voted 0 for the frame in rx_data
//   overrun_err  - sticky; a frame completed while data_avail was set
//   break_det    - one-cycle pulse on an all-zero frame
//   busy         - receiver not idle
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rxd,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 data_avail,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int unsigned   CW        = clog2(OVERSAMPLE);
    localparam int unsigned   BW        = clog2(DATA_BITS + 1);
    localparam int unsigned   MID       = mid_point(OVERSAMPLE);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_t            state, state_n;
    logic [BW-1:0]        bitcnt, bitcnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_n;
    logic                 fpend, fpend_n;   // some stop bit voted 0 so far
    logic                 szero, szero_n;   // every stop bit voted 0 so far
    logic                 done;             // non-break completion on this tick
    logic                 brk;              // break completion on this tick
    logic                 frame_final;
    logic                 parity_final;

    logic [CW-1:0]        cnt;
    logic                 vote;
    logic                 vote_strobe;
    logic                 bit_end;
    logic                 restart;

    assign restart = (state == IDLE) || (state == BRK_WAIT);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rxd         (rxd),
        .restart     (restart),
        .cnt         (cnt),
        .vote        (vote),
        .vote_strobe (vote_strobe),
        .bit_end     (bit_end)
    );

    assign parity_final = (PARITY_EN != 0) && ((^shift ^ par_bit) != PAR_MODE);
    assign frame_final  = fpend | ~vote;

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        par_n    = par_bit;
        fpend_n  = fpend;
        szero_n  = szero;
        done     = 1'b0;
        brk      = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (!rxd) state_n = START;
                end
                START: begin
                    if (vote_strobe && vote) begin
                        state_n = IDLE;
                    end else if (bit_end) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    if (vote_strobe) begin
                        for (int unsigned i = 0; i < DATA_BITS; i++) begin
                            if (BW'(i) == bitcnt) shift_n[i] = vote;
                        end
                    end else if (bit_end) begin
                        if (bitcnt == DATA_LAST) begin
                            state_n  = (PARITY_EN != 0) ? PARITY : STOP;
                            bitcnt_n = '0;
                            fpend_n  = 1'b0;
                            szero_n  = 1'b1;
                        end else begin
                            bitcnt_n = bitcnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (vote_strobe) begin
                        par_n = vote;
                    end else if (bit_end) begin
                        state_n = STOP;
                    end
                end
                STOP: begin
                    if (vote_strobe) begin
                        fpend_n = frame_final;
                        szero_n = szero & ~vote;
                        // Last stop bit finishes at its vote so an early start edge is not missed.
                        if (bitcnt == STOP_LAST) begin
                            if ((shift == '0) && ((PARITY_EN == 0) || !par_bit) && szero && !vote) begin
                                brk     = 1'b1;
                                state_n = BRK_WAIT;
                            end else begin
                                done    = 1'b1;
                                state_n = IDLE;
                            end
                        end
                    end else if (bit_end) begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
                BRK_WAIT: begin
                    if (rxd) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            fpend       <= 1'b0;
            szero       <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            data_avail  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shift     <= shift_n;
            par_bit   <= par_n;
            fpend     <= fpend_n;
            szero     <= szero_n;
            rx_valid  <= done;
            break_det <= brk;
            if (done) begin
                rx_data    <= shift;
                parity_err <= parity_final;
                frame_err  <= frame_final;
                data_avail <= 1'b1;
                // A read landing with the new frame consumes the old one, so no overrun.
                if (data_avail && !rx_rd) begin
                    overrun_err <= 1'b1;
                end else if (rx_rd) begin
                    overrun_err <= 1'b0;
                end
            end else if (rx_rd && data_avail) begin
                data_avail  <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

    a_vote_pos: assert property (@(posedge clk) disable iff (rst)
        vote_strobe |-> (cnt == CW'(MID + 1)));

endmodule
